ps2_kbd_rx: RTL and testbench
=============================

# ps2_kbd_rx

- Receives PS/2 keyboard frames on the raw `ps2_clk`/`ps2_data` pins and checks framing and parity.
- Buffers valid scan codes in a small FIFO and presents them to the downstream scan-code lookup stage. That stage is built from the key/value mux and maps codes to ASCII and segment patterns.
- Everything runs in the system clock domain; the PS/2 pins are treated as asynchronous inputs.

## Interface

Parameters:
- `FIFO_DEPTH`, default 8: number of scan-code entries; power of two, ≥2.
- `TIMEOUT_CYC`, default 50000: idle `clk` cycles mid-frame before the frame is aborted.

Ports:
- `clk`  in  1  system clock. One clock domain; everything is synchronous to its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock; asynchronous.
- `ps2_data`  in  1  raw PS/2 data; asynchronous.
- `rd_en`  in  1  pop request from the downstream stage.
- `data`  out  8  scan code at the FIFO head. Only meaningful while `ready`=1.
- `ready`  out  1  FIFO non-empty.
- `overflow`  out  1  sticky: a valid frame was dropped because the FIFO was full.
- `frame_err`  out  1  one-cycle pulse: frame rejected, or frame aborted by timeout.

## Operation

Input conditioning:
- `ps2_clk` passes through a 2-flop synchronizer, then a history register.
- A falling edge is detected when history=1 and synchronized=0.

Receiver:
- State is a bit counter `cnt` 0..10; `cnt`=0 is idle.
- On each falling edge, the sampled `ps2_data` is stored in bit position `cnt`, and `cnt` increments.
- Bit order on the wire: bit0 start (must be 0), bits1-8 data LSB first, bit9 odd parity, bit10 stop (must be 1).
- On the edge with `cnt`=10, the frame is evaluated and `cnt` returns to 0. The frame is valid when all of the following hold:
  - start bit = 0
  - stop bit = 1
  - XOR of the 8 data bits and the parity bit = 1
- Valid frame:
  - FIFO not full: the data byte is written at `wr_ptr`, `wr_ptr` increments.
  - FIFO full: the byte is dropped and `overflow` is set.
- Invalid frame: the byte is dropped and `frame_err` pulses for one cycle.

FIFO:
- Read pointer and write pointer, each log2(`FIFO_DEPTH`)+1 bits wide.
- Empty when the pointers are equal. Full when the MSBs differ and the remaining bits are equal.
- Pointers wrap modulo 2·`FIFO_DEPTH`.
- `data` is a combinational read of the entry at `rd_ptr`.
- `rd_en` while `ready`=1 increments `rd_ptr`. `rd_en` while `ready`=0 is ignored.

`overflow`:
- Set when a valid frame is dropped.
- Cleared on the first accepted pop after it was set, and by `rst`.
- If a set and a clear happen in the same cycle, set wins.

Boundary cases:
- Push and pop in the same cycle while full: both happen; the push is accepted and `overflow` is not set.
- Push and pop in the same cycle while empty: the push happens and the pop is ignored.
- `rst` mid-frame:
  - `cnt` returns to 0.
  - Pointers return to 0, and FIFO contents are cleared to 0.
  - All outputs take their reset values on the next edge.
  - The partially received frame is discarded.

## Timing

- Reset values: `data`=0x00, `ready`=0, `overflow`=0, `frame_err`=0.
- Edge-detect latency: 3 `clk` cycles from the `ps2_clk` fall to the sampling cycle.
- `ps2_clk` must hold each level for at least 4 `clk` cycles.
- Push latency: the sampling cycle of bit 10 is the write cycle.
  - `ready` and `data` are valid on the following cycle.
  - `frame_err` and `overflow` assert on that same following cycle.
- Pop: `data` shows the next entry one cycle after the `rd_en` edge.
- Back-to-back pops every cycle are supported.

## Configuration

Macro: `PS2_KBD_TIMEOUT_EN`.

Defined:
- A counter, sized for `TIMEOUT_CYC`, resets to 0 on every detected falling edge and whenever `cnt`=0.
- When the counter reaches `TIMEOUT_CYC`−1 with `cnt`≠0:
  - `cnt` returns to 0,
  - `frame_err` pulses once,
  - no push happens.

Undefined:
- No counter is built.
- A stalled partial frame waits indefinitely.
- The next edges continue the same frame.

## Test plan

- **Single valid frame:** send 0x1C (parity 0) → `ready`=1 and `data`=0x1C one cycle after bit 10. Pulse `rd_en` → `ready`=0.
- **Two codes, FIFO order:** send 0xF0 (parity 1) then 0x1C → pop order 0xF0, 0x1C; `frame_err` stays 0 throughout.
- **Error frames:** send 0x1C with parity 1 → one-cycle `frame_err`, `ready` stays 0. Then send 0x1C with stop bit 0 → same result.
- **Overflow:** send 9 codes 0x01..0x09 without popping → `overflow`=1, FIFO holds 0x01..0x08. One pop → `overflow`=0 and `data`=0x02.
- **Simultaneous push and pop when full:** FIFO full, hold `rd_en`=1 through the write cycle of a 0x55 frame → `overflow` stays 0, 0x55 becomes the last entry.
- **Timeout and reset** (with `PS2_KBD_TIMEOUT_EN`):
  - Send 5 bits, then idle for `TIMEOUT_CYC` cycles → `frame_err` pulses once. A following 0x1C frame is received correctly.
  - Separately, assert `rst` after 6 bits → all outputs 0. A following 0x1C frame is received correctly.

Source files
------------

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx -- PS/2 keyboard frame receiver with scan-code FIFO.
//
// Samples the raw PS/2 clock/data pins in the system clock domain, assembles
// 11-bit frames (start, 8 data LSB first, odd parity, stop), checks framing
// and parity, and queues valid scan codes in a FIFO for the lookup stage.
//
// Optional feature macro: PS2_KBD_TIMEOUT_EN
//   defined   : a mid-frame idle watchdog aborts stalled frames after
//               TIMEOUT_CYC clk cycles and pulses frame_err.
//   undefined : no watchdog; a stalled frame simply resumes on later edges.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ps2_clk    raw PS/2 clock (asynchronous)
//   ps2_data   raw PS/2 data (asynchronous)
//   rd_en      pop request; ignored while the FIFO is empty
//   data[7:0]  scan code at the FIFO head (meaningful while ready=1)
//   ready      FIFO non-empty
//   overflow   sticky: a valid frame was dropped on a full FIFO
//   frame_err  one-cycle pulse: bad frame, or frame aborted by timeout

module ps2_kbd_rx #(
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    // Input conditioning: both pins are synchronized; ps2_clk also keeps a
    // history bit for falling-edge detection.
    logic clk_sync1_q, clk_sync2_q, clk_hist_q;
    logic dat_sync1_q, dat_sync2_q;

    // Receiver: cnt_q is the bit index of the next bit; 0 means idle.
    logic [3:0]  cnt_q, cnt_d;
    logic [9:0]  frame_q, frame_d;   // bits 0..9; bit 10 is used as sampled

    // FIFO: one extra pointer bit separates full from empty.
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [7:0]    mem_d [FIFO_DEPTH];

    logic overflow_q, overflow_d;
    logic frame_err_q, frame_err_d;

    logic fall, frame_end, frame_ok, timeout;
    logic fifo_empty, fifo_full, pop, push_try, push, drop;

`ifdef PS2_KBD_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);
    logic [TW-1:0] to_q, to_d;

    always_comb begin
        to_d = to_q;
        if (fall || cnt_q == 4'd0)
            to_d = '0;
        else if (to_q != TO_LAST)
            to_d = to_q + 1'b1;
        // A real edge in the same cycle keeps the frame alive.
        timeout = (cnt_q != 4'd0) && (to_q == TO_LAST) && !fall;
    end

    always_ff @(posedge clk) begin
        if (rst) to_q <= '0;
        else     to_q <= to_d;
    end
`else
    // The timeout length has no effect in this build.
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = 32'(TIMEOUT_CYC);
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it
        // unassigned -- otherwise synthesis infers a latch.
        cnt_d       = cnt_q;
        frame_d     = frame_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_d       = mem_q;
        overflow_d  = overflow_q;

        fall      = clk_hist_q & ~clk_sync2_q;
        frame_end = fall && (cnt_q == 4'd10);
        // start=0, stop (the bit being sampled now)=1, data^parity odd.
        frame_ok  = ~frame_q[0] & dat_sync2_q & (^frame_q[9:1]);

        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

        pop      = rd_en & ~fifo_empty;
        push_try = frame_end & frame_ok;
        // A pop in the write cycle frees the slot, so a full FIFO still
        // accepts the push.
        push     = push_try & (~fifo_full | pop);
        drop     = push_try & fifo_full & ~pop;

        if (timeout) begin
            cnt_d = 4'd0;
        end else if (fall) begin
            if (cnt_q == 4'd10) begin
                cnt_d = 4'd0;
            end else begin
                frame_d[cnt_q] = dat_sync2_q;
                cnt_d          = cnt_q + 4'd1;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = frame_q[8:1];
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop)
            rd_ptr_d = rd_ptr_q + PW'(1);

        // Set has priority over the pop-driven clear.
        if (drop)
            overflow_d = 1'b1;
        else if (pop)
            overflow_d = 1'b0;

        frame_err_d = (frame_end & ~frame_ok) | timeout;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its pre-edge inputs regardless of statement order.
        if (rst) begin
            clk_sync1_q <= 1'b1;
            clk_sync2_q <= 1'b1;
            clk_hist_q  <= 1'b1;
            dat_sync1_q <= 1'b1;
            dat_sync2_q <= 1'b1;
            cnt_q       <= 4'd0;
            frame_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            // NOTE: the storage array is cleared on reset because the head
            // entry drives data directly and must read 0x00 after reset;
            // this costs a reset on every storage bit.
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= 8'h00;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync1_q <= ps2_clk;
            clk_sync2_q <= clk_sync1_q;
            clk_hist_q  <= clk_sync2_q;
            dat_sync1_q <= ps2_data;
            dat_sync2_q <= dat_sync1_q;
            cnt_q       <= cnt_d;
            frame_q     <= frame_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            mem_q       <= mem_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = mem_q[rd_ptr_q[AW-1:0]];
    assign ready     = ~fifo_empty;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx -- randomized self-checking bench for ps2_kbd_rx.
// A queue-based reference model tracks the expected FIFO contents, the
// sticky overflow flag and the number of frame_err pulses.

module tb_ps2_kbd_rx;

    localparam int DEPTH  = 8;
    localparam int TO_CYC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    ps2_kbd_rx #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rd_en     (rd_en),
        .data      (data),
        .ready     (ready),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [7:0] q[$];
    logic       ovf_exp = 1'b0;
    int         exp_ferr = 0;
    int         ferr_seen = 0;

    int n_vec = 0;
    int n_err = 0;

    always @(negedge clk) if (frame_err === 1'b1) ferr_seen++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, "_ready"}, 32'(ready), 32'(q.size() != 0));
        if (q.size() != 0) check({tag, "_data"}, 32'(data), 32'(q[0]));
        check({tag, "_ovf"}, 32'(overflow), 32'(ovf_exp));
    endtask

    // Model of one frame end, with an optional pop in the same cycle.
    task automatic model_write(input bit valid, input logic [7:0] b, input bit pop_req);
        bit pop_ok, set;
        pop_ok = pop_req && (q.size() != 0);
        set    = 1'b0;
        if (!valid) exp_ferr++;
        if (pop_ok) void'(q.pop_front());
        if (valid) begin
            if (q.size() < DEPTH) q.push_back(b);
            else                  set = 1'b1;
        end
        if (set)         ovf_exp = 1'b1;
        else if (pop_ok) ovf_exp = 1'b0;
    endtask

    task automatic drive_bit(input logic b);
        ps2_data = b;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start.
    task automatic send_frame(input logic [7:0] b, input int kind, input bit pop_wr);
        logic [10:0] f;
        bit valid;
        f[0]   = (kind == 3);
        f[8:1] = b;
        f[9]   = ~(^b) ^ (kind == 1);
        f[10]  = ~(kind == 2);
        valid  = (kind == 0);
        for (int i = 0; i < 10; i++) drive_bit(f[i]);
        ps2_data = f[10];
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (2) @(negedge clk);           // synchronizer stages
        check("pre_wr_ferr", 32'(frame_err), 32'd0);
        check("pre_wr_ready", 32'(ready), 32'(q.size() != 0));
        if (pop_wr) rd_en = 1'b1;
        @(negedge clk);                      // write cycle has just passed
        rd_en = 1'b0;
        model_write(valid, b, pop_wr);
        check("wr_ferr", 32'(frame_err), 32'(!valid));
        check_state("wr");
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic pop_one();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() != 0) begin
            void'(q.pop_front());
            ovf_exp = 1'b0;
        end
        check_state("pop");
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_data", 32'(data), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        repeat (4) @(negedge clk);

        // Single valid frame, then pop to empty.
        send_frame(8'h1C, 0, 1'b0);
        pop_one();

        // Two codes, FIFO order.
        send_frame(8'hF0, 0, 1'b0);
        send_frame(8'h1C, 0, 1'b0);
        pop_one();
        pop_one();
        check("order_ferr", 32'(ferr_seen), 32'(exp_ferr));

        // Error frames.
        send_frame(8'h1C, 1, 1'b0);
        send_frame(8'h1C, 2, 1'b0);
        send_frame(8'h1C, 3, 1'b0);

        // Overflow.
        for (int i = 1; i <= 9; i++) send_frame(8'(i), 0, 1'b0);
        check("ovf_set", 32'(overflow), 32'd1);
        pop_one();
        check("ovf_pop_data", 32'(data), 32'h02);
        check("ovf_clr", 32'(overflow), 32'd0);

        // Refill, then push and pop together while full.
        send_frame(8'h0A, 0, 1'b0);
        check("full_ready", 32'(q.size()), 32'(DEPTH));
        send_frame(8'h55, 0, 1'b1);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        check("full_pp_tail", 32'(q[DEPTH-1]), 32'h55);
        while (q.size() != 0) pop_one();

        // Push with pop while empty: the pop is ignored.
        send_frame(8'h33, 0, 1'b1);
        pop_one();

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            int r, k, np;
            r  = int'($urandom_range(0, 9));
            k  = (r < 7) ? 0 : r - 6;
            send_frame(8'($urandom), k, ($urandom_range(0, 3) == 0));
            np = int'($urandom_range(0, 2));
            for (int j = 0; j < np; j++) pop_one();
        end
        while (q.size() != 0) pop_one();

`ifdef PS2_KBD_TIMEOUT_EN
        // Stalled partial frame is aborted by the watchdog.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (TO_CYC + 20) @(negedge clk);
        exp_ferr++;
        check("to_ferr_count", 32'(ferr_seen), 32'(exp_ferr));
        check_state("to");
        send_frame(8'h1C, 0, 1'b0);
        pop_one();
`endif

        // Reset in the middle of a frame.
        send_frame(8'h77, 0, 1'b0);
        drive_bit(1'b0);
        for (int i = 0; i < 5; i++) drive_bit(1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        ovf_exp = 1'b0;
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_data", 32'(data), 32'd0);
        check("mid_rst_ovf", 32'(overflow), 32'd0);
        check("mid_rst_ferr", 32'(frame_err), 32'd0);
        repeat (6) @(negedge clk);
        send_frame(8'h1C, 0, 1'b0);
        pop_one();

        repeat (4) @(negedge clk);
        check("ferr_count", 32'(ferr_seen), 32'(exp_ferr));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
